// File: rtl/serial_pkg.sv
// ============================================================================
// Module  : serial_pkg
// Brief   : Shared types and defaults for the serial word assembler path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : serial_pkg

`default_nettype wire

// File: rtl/vector_reversal.sv
// ============================================================================
// Module  : vector_reversal
// Brief   : Combinational bit-order reversal of one word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_reversal
  import serial_pkg::*;
(
  input  word_t i_vec,
  output word_t o_vec
);

  always_comb begin
    o_vec = '0;
    for (int i = 0; i < DEFAULT_WIDTH; i++) begin
      o_vec[i] = i_vec[DEFAULT_WIDTH-1-i];
    end
  end

endmodule : vector_reversal

`default_nettype wire

// File: rtl/serial_word_assembler.sv
// ============================================================================
// Module  : serial_word_assembler
// Brief   : Collects a serial bit stream into words behind a valid/ready
//           output holding register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_word_assembler
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int                c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [WIDTH-1:0]   r_shreg;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_out_data;
  out_state_t         r_state;
  out_state_t         w_state_next;

  logic [WIDTH-1:0]   w_shreg_next;
  logic               w_last;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shreg_next = {r_shreg[WIDTH-2:0], in_bit};
    end else begin : g_lsb_first
      assign w_shreg_next = {in_bit, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  // Only the completing bit stalls while an unconsumed word is held.
  assign w_last     = (r_cnt == c_LAST);
  assign w_in_ready = !((r_state == OUT_FULL) && !out_ready && w_last);
  assign w_accept   = in_valid && w_in_ready && !clear;
  assign w_complete = w_accept && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shreg <= w_shreg_next;
      r_cnt   <= w_last ? '0 : (r_cnt + c_ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= OUT_EMPTY;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_complete) begin
        r_out_data <= w_shreg_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      OUT_EMPTY: begin
        if (w_complete) begin
          w_state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        // A completion alongside a handshake replaces the word with no bubble.
        if (!w_complete && out_ready) begin
          w_state_next = OUT_EMPTY;
        end
      end
      default: w_state_next = OUT_EMPTY;
    endcase
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == OUT_FULL);
  assign out_data  = r_out_data;
  assign bit_cnt   = r_cnt;

endmodule : serial_word_assembler

`default_nettype wire
